// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared pipeline definitions: register-index and ALU-op widths, ALU encodings
// and the packed control bundle carried from ID into EX.
package id_ex_pipe_reg_pkg;

    localparam int unsigned ALU_OP_W  = 4;
    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9,
        AluLui  = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic                branch;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: decoded ID fields in, registered EX fields and hazard
// status out. master = ID/EX control side, slave = the pipeline register.
interface id_ex_pipe_reg_if
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) ();

    logic                 id_valid;
    logic [XLEN-1:0]      id_pc;
    logic [XLEN-1:0]      id_rs1_data;
    logic [XLEN-1:0]      id_rs2_data;
    logic [XLEN-1:0]      id_imm;
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic [REG_IDX_W-1:0] id_rd;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic                 id_reg_write;
    logic                 id_mem_read;
    logic                 id_mem_write;
    logic                 id_mem_to_reg;
    logic                 id_alu_src;
    logic                 id_branch;
    logic [ALU_OP_W-1:0]  id_alu_op;
    logic                 ex_flush;
    logic                 ex_stall;
    logic                 cnt_clr;

    logic                 ex_valid;
    logic [XLEN-1:0]      ex_pc;
    logic [XLEN-1:0]      ex_rs1_data;
    logic [XLEN-1:0]      ex_rs2_data;
    logic [XLEN-1:0]      ex_imm;
    logic [REG_IDX_W-1:0] ex_rs1;
    logic [REG_IDX_W-1:0] ex_rs2;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_reg_write;
    logic                 ex_mem_read;
    logic                 ex_mem_write;
    logic                 ex_mem_to_reg;
    logic                 ex_alu_src;
    logic                 ex_branch;
    logic [ALU_OP_W-1:0]  ex_alu_op;
    logic                 id_hold;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, id_alu_src, id_branch, id_alu_op, ex_flush, ex_stall, cnt_clr,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch,
               ex_alu_op, id_hold, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, id_alu_src, id_branch, id_alu_op, ex_flush, ex_stall, cnt_clr,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch,
               ex_alu_op, id_hold, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/id_ex_pipe_reg_hazard_detect.sv
// Load-use hazard check: the instruction in ID reads a register that a valid
// load currently in EX will write. x0 never creates a hazard.
module id_ex_pipe_reg_hazard_detect
    import id_ex_pipe_reg_pkg::*;
(
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // Source matches only count when the instruction really reads that field.
    always_comb begin
        rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
        load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX-branch flush,
// downstream-stall freeze and saturating bubble counters.
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    id_ex_pipe_reg_if.slave bus
);

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [XLEN-1:0]      imm;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        ctrl_t                ctrl;
    } stage_t;

    // Bubble zeroes indices too, so the forwarding unit can never match on it.
    localparam stage_t Bubble = '{
        valid: 1'b0, pc: '0, rs1_data: '0, rs2_data: '0, imm: '0,
        rs1: '0, rs2: '0, rd: '0, ctrl: BUBBLE_CTRL
    };
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t           ex_q, ex_d, id_stage;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;

    id_ex_pipe_reg_hazard_detect u_hazard_detect (
        .id_valid    (bus.id_valid),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs1 (bus.id_uses_rs1),
        .id_uses_rs2 (bus.id_uses_rs2),
        .ex_valid    (ex_q.valid),
        .ex_mem_read (ex_q.ctrl.mem_read),
        .ex_rd       (ex_q.rd),
        .load_use    (load_use)
    );

    // Gather the ID inputs into one record for capture.
    always_comb begin
        id_stage                 = Bubble;
        id_stage.valid           = bus.id_valid;
        id_stage.pc              = bus.id_pc;
        id_stage.rs1_data        = bus.id_rs1_data;
        id_stage.rs2_data        = bus.id_rs2_data;
        id_stage.imm             = bus.id_imm;
        id_stage.rs1             = bus.id_rs1;
        id_stage.rs2             = bus.id_rs2;
        id_stage.rd              = bus.id_rd;
        id_stage.ctrl.reg_write  = bus.id_reg_write;
        id_stage.ctrl.mem_read   = bus.id_mem_read;
        id_stage.ctrl.mem_write  = bus.id_mem_write;
        id_stage.ctrl.mem_to_reg = bus.id_mem_to_reg;
        id_stage.ctrl.alu_src    = bus.id_alu_src;
        id_stage.ctrl.branch     = bus.id_branch;
        id_stage.ctrl.alu_op     = bus.id_alu_op;
    end

    // Next state: stall freezes, then flush, then load-use bubble, then capture.
    always_comb begin
        ex_d        = ex_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!bus.ex_stall) begin
            if (bus.ex_flush) begin
                ex_d = Bubble;
                if (bus.id_valid && (flush_cnt_q != CntMax)) begin
                    flush_cnt_d = flush_cnt_q + CntOne;
                end
            end else if (load_use) begin
                ex_d = Bubble;
                if (stall_cnt_q != CntMax) begin
                    stall_cnt_d = stall_cnt_q + CntOne;
                end
            end else if (bus.id_valid) begin
                ex_d = id_stage;
            end else begin
                // An empty ID slot travels as a bubble but is not counted.
                ex_d = Bubble;
            end
        end
        if (bus.cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= Bubble;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // A taken branch squashes the hazarding instruction, so it need not be held.
    assign bus.id_hold       = bus.ex_stall | (load_use & ~bus.ex_flush);
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_rs1_data   = ex_q.rs1_data;
    assign bus.ex_rs2_data   = ex_q.rs2_data;
    assign bus.ex_imm        = ex_q.imm;
    assign bus.ex_rs1        = ex_q.rs1;
    assign bus.ex_rs2        = ex_q.rs2;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_reg_write  = ex_q.ctrl.reg_write;
    assign bus.ex_mem_read   = ex_q.ctrl.mem_read;
    assign bus.ex_mem_write  = ex_q.ctrl.mem_write;
    assign bus.ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
    assign bus.ex_alu_src    = ex_q.ctrl.alu_src;
    assign bus.ex_branch     = ex_q.ctrl.branch;
    assign bus.ex_alu_op     = ex_q.ctrl.alu_op;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: hand-derived vector table, saturation sequence and
// randomized traffic against a behavioural model of the ID/EX rules.
module tb_id_ex_pipe_reg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    id_ex_pipe_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rstn;
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, rw, mr, mw, m2r, as, br;
        logic [3:0]  op;
        logic        flush, stall, clr;
    } vin_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, m2r, as, br;
        logic [3:0]  op;
    } exs_t;

    typedef struct {
        vin_t        in;
        int          hold;
        logic        valid;
        logic [4:0]  rd, rs1;
        logic [31:0] d1, pc;
        int          sc, fc;
    } vec_t;

    exs_t m;
    int   m_sc, m_fc;
    bit   m_ok;
    int   total, bad;
    vec_t tbl[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vin_t ins(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                 input logic u2, input logic rw, input logic mr,
                                 input logic [31:0] d1);
        vin_t x;
        x = '0;
        x.rstn = 1'b1; x.valid = v; x.pc = pc; x.d1 = d1; x.d2 = d1 + 32'd100;
        x.imm = pc + 32'd4; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2; x.u1 = u1; x.u2 = u2;
        x.rw = rw; x.mr = mr; x.m2r = mr; x.as = mr; x.op = rd[3:0];
        return x;
    endfunction

    function automatic vin_t ctl(input vin_t x, input logic rstn, input logic fl,
                                 input logic st, input logic clr);
        vin_t y;
        y = x; y.rstn = rstn; y.flush = fl; y.stall = st; y.clr = clr;
        return y;
    endfunction

    function automatic exs_t dut_ex();
        exs_t e;
        e.valid = bus.ex_valid; e.pc = bus.ex_pc; e.d1 = bus.ex_rs1_data;
        e.d2 = bus.ex_rs2_data; e.imm = bus.ex_imm; e.rs1 = bus.ex_rs1; e.rs2 = bus.ex_rs2;
        e.rd = bus.ex_rd; e.rw = bus.ex_reg_write; e.mr = bus.ex_mem_read;
        e.mw = bus.ex_mem_write; e.m2r = bus.ex_mem_to_reg; e.as = bus.ex_alu_src;
        e.br = bus.ex_branch; e.op = bus.ex_alu_op;
        return e;
    endfunction

    // A load in EX writing a nonzero register that the ID instruction reads.
    function automatic logic model_lu(input vin_t x);
        return x.valid && m.valid && m.mr && (m.rd != 5'd0) &&
               ((x.u1 && x.rs1 == m.rd) || (x.u2 && x.rs2 == m.rd));
    endfunction

    task automatic drive(input vin_t x);
        rst_n = x.rstn;
        bus.id_valid = x.valid; bus.id_pc = x.pc; bus.id_rs1_data = x.d1;
        bus.id_rs2_data = x.d2; bus.id_imm = x.imm; bus.id_rs1 = x.rs1; bus.id_rs2 = x.rs2;
        bus.id_rd = x.rd; bus.id_uses_rs1 = x.u1; bus.id_uses_rs2 = x.u2;
        bus.id_reg_write = x.rw; bus.id_mem_read = x.mr; bus.id_mem_write = x.mw;
        bus.id_mem_to_reg = x.m2r; bus.id_alu_src = x.as; bus.id_branch = x.br;
        bus.id_alu_op = x.op; bus.ex_flush = x.flush; bus.ex_stall = x.stall;
        bus.cnt_clr = x.clr;
    endtask

    // Apply one cycle: check id_hold before the edge, then model vs DUT after it.
    task automatic step(input vin_t x, input string tag, input int hold_exp);
        logic lu;
        exs_t cap;
        drive(x);
        #1;
        lu = model_lu(x);
        if (m_ok) check({tag, "_hold_model"}, 256'(bus.id_hold), 256'(x.stall | (lu & ~x.flush)));
        if (hold_exp >= 0) check({tag, "_hold"}, 256'(bus.id_hold), 256'(hold_exp));
        @(posedge clk);
        #1;
        cap = '{valid: x.valid, pc: x.pc, d1: x.d1, d2: x.d2, imm: x.imm, rs1: x.rs1,
                rs2: x.rs2, rd: x.rd, rw: x.rw, mr: x.mr, mw: x.mw, m2r: x.m2r, as: x.as,
                br: x.br, op: x.op};
        if (!x.rstn) begin
            m = '0; m_sc = 0; m_fc = 0;
        end else begin
            if (!x.stall) begin
                if (x.flush) begin
                    m = '0;
                    if (x.valid) m_fc = (m_fc + 1 > CNT_MAX) ? CNT_MAX : m_fc + 1;
                end else if (lu) begin
                    m = '0;
                    m_sc = (m_sc + 1 > CNT_MAX) ? CNT_MAX : m_sc + 1;
                end else begin
                    m = x.valid ? cap : '0;
                end
            end
            if (x.clr) begin
                m_sc = 0; m_fc = 0;
            end
        end
        m_ok = 1'b1;
        check({tag, "_ex"}, 256'(dut_ex()), 256'(m));
        check({tag, "_stall_cnt"}, 256'(bus.stall_cnt), 256'(m_sc));
        check({tag, "_flush_cnt"}, 256'(bus.flush_cnt), 256'(m_fc));
    endtask

    function automatic vec_t row(input vin_t x, input int hold, input logic v,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [31:0] d1, input logic [31:0] pc,
                                 input int sc, input int fc);
        vec_t r;
        r.in = x; r.hold = hold; r.valid = v; r.rd = rd; r.rs1 = rs1; r.d1 = d1; r.pc = pc;
        r.sc = sc; r.fc = fc;
        return r;
    endfunction

    initial begin
        vin_t add_h, lw5, use5, x;
        total = 0; bad = 0; m = '0; m_sc = 0; m_fc = 0; m_ok = 1'b0;

        // Reset with live inputs (clear request under reset is ignored).
        tbl.push_back(row(ctl(ins(1, 'h200, 9, 3, 4, 1, 1, 1, 1, 'h33), 0, 0, 0, 0),
                          -1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(row(ctl(ins(1, 'h204, 5, 5, 6, 1, 1, 1, 0, 'h44), 0, 0, 0, 1),
                          0, 0, 0, 0, 0, 0, 0, 0));
        // Pass-through add x3,x1,x2.
        tbl.push_back(row(ins(1, 'h100, 3, 1, 2, 1, 1, 1, 0, 5), 0, 1, 3, 1, 5, 'h100, 0, 0));
        // lw x5 then add x6,x5,x1: one bubble, then the add enters EX.
        tbl.push_back(row(ins(1, 'h104, 5, 2, 0, 1, 0, 1, 1, 9), 0, 1, 5, 2, 9, 'h104, 0, 0));
        tbl.push_back(row(ins(1, 'h108, 6, 5, 1, 1, 1, 1, 0, 11), 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(row(ins(1, 'h108, 6, 5, 1, 1, 1, 1, 0, 11), 0, 1, 6, 5, 11, 'h108, 1, 0));
        // lw x0 then reader of x0: no stall.
        tbl.push_back(row(ins(1, 'h10c, 0, 1, 0, 1, 0, 1, 1, 13), 0, 1, 0, 1, 13, 'h10c, 1, 0));
        tbl.push_back(row(ins(1, 'h110, 7, 0, 0, 1, 1, 1, 0, 15), 0, 1, 7, 0, 15, 'h110, 1, 0));
        // lw x5 then I-type whose unused rs2 field is 5: no stall.
        tbl.push_back(row(ins(1, 'h114, 5, 1, 0, 1, 0, 1, 1, 17), 0, 1, 5, 1, 17, 'h114, 1, 0));
        tbl.push_back(row(ins(1, 'h118, 8, 1, 5, 1, 0, 1, 0, 19), 0, 1, 8, 1, 19, 'h118, 1, 0));
        // Flush coinciding with a load-use: flush wins, no hold.
        tbl.push_back(row(ins(1, 'h11c, 9, 2, 0, 1, 0, 1, 1, 21), 0, 1, 9, 2, 21, 'h11c, 1, 0));
        tbl.push_back(row(ctl(ins(1, 'h120, 10, 9, 9, 1, 1, 1, 0, 23), 1, 1, 0, 0),
                          0, 0, 0, 0, 0, 0, 1, 1));
        // Downstream stall for 3 cycles over a load-use, then one bubble.
        tbl.push_back(row(ins(1, 'h124, 4, 3, 0, 1, 0, 1, 1, 25), 0, 1, 4, 3, 25, 'h124, 1, 1));
        add_h = ins(1, 'h128, 11, 4, 2, 1, 1, 1, 0, 27);
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(row(ctl(add_h, 1, 0, 1, 0), 1, 1, 4, 3, 25, 'h124, 1, 1));
        end
        tbl.push_back(row(add_h, 1, 0, 0, 0, 0, 0, 2, 1));
        tbl.push_back(row(add_h, 0, 1, 11, 4, 27, 'h128, 2, 1));
        // Empty ID slot captured as zeros; counter clear.
        tbl.push_back(row(ctl(ins(0, 'h12c, 12, 4, 5, 1, 1, 1, 1, 29), 1, 0, 0, 1),
                          0, 0, 0, 0, 0, 0, 0, 0));
        // Flush of an empty slot is not counted; of a real one is.
        tbl.push_back(row(ctl(ins(0, 'h130, 13, 1, 1, 1, 1, 1, 0, 31), 1, 1, 0, 0),
                          0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(row(ctl(ins(1, 'h134, 14, 1, 1, 1, 1, 1, 0, 33), 1, 1, 0, 0),
                          0, 0, 0, 0, 0, 0, 0, 1));
        // Reset during a stall with a pending hazard: nothing survives.
        tbl.push_back(row(ins(1, 'h138, 5, 1, 0, 1, 0, 1, 1, 35), 0, 1, 5, 1, 35, 'h138, 0, 1));
        tbl.push_back(row(ctl(ins(1, 'h13c, 6, 5, 5, 1, 1, 1, 0, 37), 0, 0, 1, 0),
                          1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(row(ins(1, 'h13c, 6, 5, 5, 1, 1, 1, 0, 37), 0, 1, 6, 5, 37, 'h13c, 0, 0));

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("row%0d", i);
            step(tbl[i].in, tag, tbl[i].hold);
            check({tag, "_vec"},
                  256'({bus.ex_valid, bus.ex_rd, bus.ex_rs1, bus.ex_rs1_data, bus.ex_pc,
                        bus.stall_cnt, bus.flush_cnt}),
                  256'({tbl[i].valid, tbl[i].rd, tbl[i].rs1, tbl[i].d1, tbl[i].pc,
                        4'(tbl[i].sc), 4'(tbl[i].fc)}));
        end

        // Stall counter saturates at all-ones.
        lw5  = ins(1, 'h300, 5, 1, 0, 1, 0, 1, 1, 'h77);
        use5 = ins(1, 'h304, 6, 5, 1, 1, 1, 1, 0, 'h88);
        for (int k = 1; k <= CNT_MAX + 2; k++) begin
            step(lw5, "sat_lw", 0);
            step(use5, "sat_use", 1);
            check("sat_cnt", 256'(bus.stall_cnt), 256'((k > CNT_MAX) ? CNT_MAX : k));
            step(use5, "sat_go", 0);
        end
        check("sat_final", 256'(bus.stall_cnt), 256'(4'hF));
        step(ctl(ins(1, 'h308, 7, 1, 1, 1, 1, 1, 0, 1), 1, 1, 0, 0), "pre_clr", 0);
        step(ctl(ins(0, 'h30c, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 1), "clr", 0);
        check("clr_both", 256'({bus.stall_cnt, bus.flush_cnt}), 256'(8'h00));

        // Randomized traffic with small register indices to provoke hazards.
        for (int n = 0; n < 500; n++) begin
            x = '0;
            x.rstn  = ($urandom_range(0, 49) != 0);
            x.valid = ($urandom_range(0, 7) != 0);
            x.pc = $urandom; x.d1 = $urandom; x.d2 = $urandom; x.imm = $urandom;
            x.rs1 = 5'($urandom_range(0, 3)); x.rs2 = 5'($urandom_range(0, 3));
            x.rd  = 5'($urandom_range(0, 3));
            x.u1 = 1'($urandom); x.u2 = 1'($urandom); x.rw = 1'($urandom);
            x.mr = 1'($urandom); x.mw = 1'($urandom); x.m2r = 1'($urandom);
            x.as = 1'($urandom); x.br = 1'($urandom); x.op = 4'($urandom);
            x.flush = ($urandom_range(0, 9) == 0);
            x.stall = ($urandom_range(0, 6) == 0);
            x.clr   = ($urandom_range(0, 29) == 0);
            step(x, "rnd", -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register for the 5-stage pipelined core, with integrated load-use hazard detection, bubble insertion and EX-branch flush.
- Its registered rs1/rs2/rd/RegWrite outputs feed the forwarding unit (ID_EX_RegisterA/B) and the EX stage.
- Drives the hold signal for PC and IF/ID.
- Counts inserted stall and flush bubbles for performance debug.

Parameters:
- XLEN, 32, datapath width (pc, operands, immediate)
- CNT_W, 32, width of the stall and flush counters

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  decoded immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads that source
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch  in  1  decoded control
- id_alu_op  in  4  ALU operation
- ex_flush  in  1  branch/jump taken in EX; squash the instruction entering EX
- ex_stall  in  1  downstream stall (memory busy); freeze this register
- cnt_clr  in  1  synchronous clear of both counters
- ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_alu_op  out  matching widths  registered copies of the id_* inputs
- id_hold  out  1  combinational; PC and IF/ID must not update
- stall_cnt, flush_cnt  out  CNT_W  bubble counters

Behaviour:
- Clock and reset
  - Single clock domain.
  - Reset is synchronous, active-low: sampled on the rising edge of clk while rst_n=0.
  - On reset, every registered output is 0, including both counters.
- Load-use detection (combinational, from current register state):
  - load_use = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Per-edge update priority, highest first:
  1. rst_n=0: clear everything.
  2. ex_stall=1: all ex_* hold their values; counters hold.
  3. ex_flush=1: load a bubble. flush_cnt += 1 if id_valid=1.
  4. load_use=1: load a bubble; stall_cnt += 1.
  5. Otherwise: capture all id_* inputs; ex_valid <= id_valid.
- Bubble definition:
  - ex_valid=0.
  - All control bits and ex_alu_op = 0.
  - ex_rd = ex_rs1 = ex_rs2 = 0, so the forwarding unit never matches.
  - Data fields (pc, operands, imm) = 0.
- id_valid=0 in the normal path:
  - Captures the control bits gated to 0 and rd=0.
  - Identical to a bubble except that no counter increments.
- id_hold = ex_stall | (load_use & ~ex_flush).
- Latency:
  - Normal path: one cycle ID to EX.
  - Load-use inserts exactly one bubble. The next cycle ex_valid=0, so load_use deasserts and the held instruction enters EX one cycle later, with the loaded value forwarded from MEM/WB.
- Simultaneous events:
  - ex_flush has priority over load_use: one bubble, only flush_cnt increments, id_hold=0.
  - EX keeps ex_flush asserted for as long as ex_stall is high, so a flush is never lost.
- Counters:
  - Saturate at all-ones; never wrap.
  - cnt_clr zeroes the counters and has priority over an increment in the same cycle.
  - cnt_clr is ignored under reset, since reset already clears them.
- Reset mid-stall or mid-bubble: the next state is the reset state; no pending hazard survives.

Decomposition:
- Shared pipeline package holds:
  - ALU_OP_W=4 and the alu_op encodings
  - REG_IDX_W=5
  - a packed ctrl bundle typedef (reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op)
  - a BUBBLE_CTRL constant of all zeros
- One sub-module, hazard_detect: purely combinational load_use, shared with any future stage needing the same check.
- Counters stay inline.

Test Plan:
- Reset: drive random id_*, hold rst_n=0 for 2 edges -> all ex_* = 0, stall_cnt = flush_cnt = 0, id_hold = 0.
- Pass-through: add x3,x1,x2 (pc=0x100, rs1_data=5, rs2_data=7, reg_write=1) -> next edge ex_valid=1, ex_rd=3, ex_rs1=1, ex_rs2=2, ex_rs1_data=5, ex_pc=0x100.
- Load-use: EX holds lw x5; ID presents add x6,x5,x1 -> id_hold=1 that cycle. Next edge: ex_valid=0, ex_rd=0, stall_cnt=1, id_hold=0. Following edge: add captured with ex_rs1=5.
- No false stall:
  - lw x0 followed by a reader of x0 -> id_hold=0.
  - lw x5 followed by an I-type with rs2 field 5 and id_uses_rs2=0 -> id_hold=0.
- Flush vs load-use: load_use and ex_flush=1 in the same cycle -> id_hold=0, bubble loaded, flush_cnt=1, stall_cnt unchanged.
- Downstream stall and counters:
  - ex_stall=1 for 3 cycles with a load-use present -> ex_* frozen, id_hold=1, counters unchanged; after release, one bubble and stall_cnt+1.
  - Preload stall_cnt to all-ones, trigger a load-use -> stall_cnt stays all-ones.
  - cnt_clr -> both counters 0.
